// File: rtl/fxp_mul_pipe_hs_if.sv
// Operand/result stream bundle for fxp_mul_pipe_hs.
// The multiplier is the slave: it consumes operand beats and produces result beats.
interface fxp_mul_pipe_hs_if #(
  parameter int A_W = 16,
  parameter int B_W = 16,
  parameter int O_W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] ina;
  logic [B_W-1:0] inb;
  logic           out_valid;
  logic           out_ready;
  logic [O_W-1:0] out;
  logic           overflow;

  modport master (
    output in_valid, ina, inb, out_ready,
    input  in_ready, out_valid, out, overflow
  );

  modport slave (
    input  in_valid, ina, inb, out_ready,
    output in_ready, out_valid, out, overflow
  );
endinterface

// File: rtl/fxp_mul_pipe_hs.sv
// Handshaked signed fixed-point multiplier with a configurable pipeline depth.
// The full-precision product runs through STAGES-1 product registers. The
// final register stage holds the rounded and saturated result. Every stage
// advances together whenever the output register is empty or being drained.
module fxp_mul_pipe_hs #(
  parameter int A_width_int       = 8,
  parameter int A_width_frac      = 8,
  parameter int B_width_int       = 8,
  parameter int B_width_frac      = 8,
  parameter int output_width_int  = 8,
  parameter int output_width_frac = 8,
  parameter int ROUND             = 1,
  parameter int STAGES            = 2
) (
  input  logic              clk,
  input  logic              rstn,
  fxp_mul_pipe_hs_if.slave  bus,
  output logic              ovf_sticky,
  input  logic              ovf_clr
);

  localparam int AW   = A_width_int + A_width_frac;
  localparam int BW   = B_width_int + B_width_frac;
  localparam int OW   = output_width_int + output_width_frac;
  localparam int PW   = AW + BW;
  localparam int PF   = A_width_frac + B_width_frac;
  localparam int DROP = PF - output_width_frac;
  localparam int RSH  = (DROP > 0) ? DROP : 0;
  localparam int LSH  = (DROP < 0) ? -DROP : 0;
  // Working width: room for the rounding carry, the fraction left shift and
  // the output-range comparison.
  localparam int WW   = PW + OW + 2;
  localparam int unsigned NP = STAGES - 1;

  // Half an LSB of the output; collapses to zero when nothing is dropped.
  localparam logic signed [WW-1:0] RND_ADD = (ROUND != 0) ? ((WW'(1) << RSH) >> 1) : '0;
  localparam logic signed [WW-1:0] MAXV    = WW'({(OW-1){1'b1}});
  localparam logic signed [WW-1:0] MINV    = ~MAXV;

  logic                 adv;
  logic signed [PW-1:0] prod_d;
  logic signed [PW-1:0] prod_q [NP];
  logic                 vld_q  [NP];
  logic signed [WW-1:0] ext;
  logic signed [WW-1:0] sum;
  logic signed [WW-1:0] aligned;
  logic [OW-1:0]        adj;
  logic                 adj_ovf;
  logic [OW-1:0]        out_q;
  logic                 ovf_q;
  logic                 ovld_q;

  assign adv           = ~ovld_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = ovld_q;
  assign bus.out       = out_q;
  assign bus.overflow  = ovf_q;

  // Sign-extend both operands to the product width so the low PW bits are exact.
  assign prod_d = $signed({{BW{bus.ina[AW-1]}}, bus.ina}) * $signed({{AW{bus.inb[BW-1]}}, bus.inb});

  // Round, realign to the output fraction and saturate to the output range.
  always_comb begin
    ext     = {{(WW-PW){prod_q[NP-1][PW-1]}}, prod_q[NP-1]};
    sum     = ext + RND_ADD;
    aligned = (sum >>> RSH) <<< LSH;
    adj     = aligned[OW-1:0];
    adj_ovf = 1'b0;
    if (aligned > MAXV) begin
      adj     = {1'b0, {(OW-1){1'b1}}};
      adj_ovf = 1'b1;
    end else if (aligned < MINV) begin
      adj     = {1'b1, {(OW-1){1'b0}}};
      adj_ovf = 1'b1;
    end
  end

  // Lock-step pipeline: product registers, then the width-adjusted result register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NP; i++) begin
        prod_q[i] <= '0;
        vld_q[i]  <= 1'b0;
      end
      out_q  <= '0;
      ovf_q  <= 1'b0;
      ovld_q <= 1'b0;
    end else if (adv) begin
      prod_q[0] <= prod_d;
      vld_q[0]  <= bus.in_valid;
      for (int unsigned i = 1; i < NP; i++) begin
        prod_q[i] <= prod_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
      out_q  <= adj;
      ovf_q  <= adj_ovf;
      ovld_q <= vld_q[NP-1];
    end
  end

  // Sticky overflow: a delivered saturated beat takes priority over a clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_sticky <= 1'b0;
    end else if (ovld_q && bus.out_ready && ovf_q) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fxp_mul_pipe_hs.sv
// Directed scoreboard bench for fxp_mul_pipe_hs.
// u_a: Q8.8, ROUND=1, STAGES=2.  u_b: Q8.8, ROUND=0, STAGES=5.
module tb_fxp_mul_pipe_hs;

  logic clk = 1'b0;
  logic rstn;
  logic ovf_clr_a, ovf_clr_b;
  logic sticky_a, sticky_b;

  always #5 clk = ~clk;

  fxp_mul_pipe_hs_if #(.A_W(16), .B_W(16), .O_W(16)) ifa ();
  fxp_mul_pipe_hs_if #(.A_W(16), .B_W(16), .O_W(16)) ifb ();

  fxp_mul_pipe_hs #(.ROUND(1), .STAGES(2)) u_a (
    .clk(clk), .rstn(rstn), .bus(ifa), .ovf_sticky(sticky_a), .ovf_clr(ovf_clr_a)
  );

  fxp_mul_pipe_hs #(.ROUND(0), .STAGES(5)) u_b (
    .clk(clk), .rstn(rstn), .bus(ifb), .ovf_sticky(sticky_b), .ovf_clr(ovf_clr_b)
  );

  int          total = 0;
  int          bad   = 0;
  int          deliv_b = 0;
  logic [16:0] q_a [$];
  logic [16:0] q_b [$];
  logic        stall_b = 1'b0;
  logic [15:0] held_b  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard for u_a: pop on every delivered beat.
  always @(negedge clk) begin : mon_a
    logic [16:0] e;
    if (rstn === 1'b1 && ifa.out_valid && ifa.out_ready) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_beat", ifa.out_valid, 0);
      end else begin
        e = q_a.pop_front();
        chk("a_out", ifa.out, e[15:0]);
        chk("a_overflow", ifa.overflow, e[16]);
      end
    end
  end

  // Scoreboard for u_b plus stall stability checks.
  always @(negedge clk) begin : mon_b
    logic [16:0] e;
    if (rstn !== 1'b1) begin
      stall_b = 1'b0;
    end else begin
      if (stall_b) begin
        chk("b_hold_valid", ifb.out_valid, 1);
        chk("b_hold_data", ifb.out, held_b);
      end
      if (ifb.out_valid && !ifb.out_ready) begin
        chk("b_stall_in_ready", ifb.in_ready, 0);
        stall_b = 1'b1;
        held_b  = ifb.out;
      end else begin
        stall_b = 1'b0;
      end
      if (ifb.out_valid && ifb.out_ready) begin
        deliv_b++;
        if (q_b.size() == 0) begin
          chk("b_unexpected_beat", ifb.out_valid, 0);
        end else begin
          e = q_b.pop_front();
          chk("b_out", ifb.out, e[15:0]);
          chk("b_overflow", ifb.overflow, e[16]);
        end
      end
    end
  end

  task automatic send_a(input logic [15:0] a, input logic [15:0] b, input logic [16:0] e);
    int   n   = 0;
    logic acc = 1'b0;
    ifa.ina = a; ifa.inb = b; ifa.in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ifa.in_ready;
      if (acc) q_a.push_back(e);
      @(posedge clk); #1;
      n++;
    end
    ifa.in_valid = 1'b0;
    if (!acc) chk("a_accept_timeout", ifa.in_ready, 1);
  endtask

  task automatic send_b(input logic [15:0] a, input logic [15:0] b, input logic [16:0] e);
    int   n   = 0;
    logic acc = 1'b0;
    ifb.ina = a; ifb.inb = b; ifb.in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ifb.in_ready;
      if (acc) q_b.push_back(e);
      @(posedge clk); #1;
      n++;
    end
    ifb.in_valid = 1'b0;
    if (!acc) chk("b_accept_timeout", ifb.in_ready, 1);
  endtask

  task automatic drain_a();
    int n = 0;
    while (q_a.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("a_drain_left", q_a.size(), 0);
  endtask

  task automatic drain_b();
    int n = 0;
    while (q_b.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b_drain_left", q_b.size(), 0);
  endtask

  initial begin
    int lat;
    int k;
    int c;
    int n;
    int seen;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    rstn = 1'b0;
    ovf_clr_a = 1'b0; ovf_clr_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.ina = '0; ifa.inb = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.ina = '0; ifb.inb = '0; ifb.out_ready = 1'b1;

    // Reset state
    #12;
    chk("a_rst_out_valid", ifa.out_valid, 0);
    chk("a_rst_out", ifa.out, 0);
    chk("a_rst_overflow", ifa.overflow, 0);
    chk("a_rst_sticky", sticky_a, 0);
    chk("a_rst_in_ready", ifa.in_ready, 1);
    chk("b_rst_out_valid", ifb.out_valid, 0);
    chk("b_rst_in_ready", ifb.in_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1.5 * 2.0 with latency measurement on u_a
    ifa.ina = 16'h0180; ifa.inb = 16'h0200; ifa.in_valid = 1'b1;
    q_a.push_back({1'b0, 16'h0300});
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    lat = 1;
    while (!ifa.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("a_latency", lat, 2);
    drain_a();

    // Saturation
    send_a(16'h6400, 16'h0200, {1'b1, 16'h7FFF});
    drain_a();
    chk("a_sticky_after_ovf", sticky_a, 1);
    send_a(16'h9C00, 16'h0200, {1'b1, 16'h8000});
    // Rounding with ROUND=1
    send_a(16'h0001, 16'h0080, {1'b0, 16'h0001});
    send_a(16'hFFFF, 16'h0080, {1'b0, 16'h0000});
    drain_a();

    // Truncation with ROUND=0 and latency of the 5-stage instance
    ifb.ina = 16'h0001; ifb.inb = 16'h0080; ifb.in_valid = 1'b1;
    q_b.push_back({1'b0, 16'h0000});
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    lat = 1;
    while (!ifb.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b_latency", lat, 5);
    drain_b();
    send_b(16'hFFFF, 16'h0080, {1'b0, 16'hFFFF});
    drain_b();

    // Back-to-back stream with out_ready pattern 1,0,0,1
    deliv_b = 0;
    k = 0;
    c = 0;
    while ((k < 10 || q_b.size() != 0) && c < 300) begin
      ifb.out_ready = pat[c % 4];
      if (k < 10) begin
        ifb.ina = 16'(k << 8); ifb.inb = 16'h0100; ifb.in_valid = 1'b1;
      end else begin
        ifb.in_valid = 1'b0;
      end
      @(negedge clk);
      if (ifb.in_valid && ifb.in_ready) begin
        q_b.push_back({1'b0, 16'(k << 8)});
        k++;
      end
      @(posedge clk); #1;
      c++;
    end
    ifb.in_valid = 1'b0;
    ifb.out_ready = 1'b1;
    chk("b_stream_sent", k, 10);
    chk("b_stream_delivered", deliv_b, 10);
    chk("b_stream_left", q_b.size(), 0);

    // Sticky: clear, then set-wins against a simultaneous clear, then clear alone
    ovf_clr_a = 1'b1;
    @(posedge clk); #1;
    ovf_clr_a = 1'b0;
    chk("a_sticky_cleared", sticky_a, 0);
    send_a(16'h6400, 16'h0200, {1'b1, 16'h7FFF});
    n = 0;
    while (!ifa.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("a_ovf_beat_present", ifa.out_valid, 1);
    ovf_clr_a = 1'b1;
    @(posedge clk); #1;
    ovf_clr_a = 1'b0;
    chk("a_sticky_set_wins", sticky_a, 1);
    ovf_clr_a = 1'b1;
    @(posedge clk); #1;
    ovf_clr_a = 1'b0;
    chk("a_sticky_clr_alone", sticky_a, 0);
    drain_a();

    // Reset with three beats in flight in u_b
    for (int i = 1; i <= 3; i++) begin
      ifb.ina = 16'(i << 8); ifb.inb = 16'h0100; ifb.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    ifb.in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("b_midrst_out_valid", ifb.out_valid, 0);
    chk("b_midrst_out", ifb.out, 0);
    chk("b_midrst_overflow", ifb.overflow, 0);
    q_b.delete();
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ifb.out_valid) seen++;
    end
    chk("b_no_stale_beats", seen, 0);
    chk("b_post_rst_in_ready", ifb.in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
